breakout_game_ctrl: RTL
=======================

Name: breakout_game_ctrl

Overview:
Frame-rate game sequencer for the breakout playfield. It owns game phase, lives, BCD score, level and ball speed. It tells the ball/paddle/brick datapath when to hold the ball on the paddle, when to re-serve, when to reload the brick wall, and when to raise endGame. All game decisions advance on the end-of-frame pulse from the sync generator; hit and loss events may arrive on any pixel clock.

Parameters:
LIVES_INIT, 3, lives at game start (1..7)
BRICK_POINTS, 1, BCD points per brick hit (1..9)
BASE_SPEED, 2, ball speed at level 1 (pixels/frame)
MAX_SPEED, 6, speed ceiling (must be <= 7)
SERVE_FRAMES, 60, frames the ball is held on the paddle before auto-launch
LOST_FRAMES, 90, frames spent in the LOST phase
LEVELUP_FRAMES, 120, frames spent in the LEVEL_UP phase

Ports:
clock  in  1  pixel clock (num[0] domain)
reset  in  1  synchronous, active-high
frame_tick  in  1  one-clock pulse at end of frame (cX==639, cY==479)
start_n  in  1  start button, active-low, already synchronised
brick_hit  in  1  one-clock pulse per brick destroyed
ball_lost  in  1  one-clock pulse: ball reached bottom border
bricks_clear  in  1  level: brickState all zero
state  out  3  0 IDLE, 1 SERVE, 2 PLAY, 3 LOST, 4 LEVEL_UP, 5 OVER
ball_hold  out  1  ball tracks the paddle; datapath freezes ball motion
ball_serve  out  1  one-clock pulse: release ball upward
brick_reload  out  1  one-clock pulse: set brickState to all ones
lives  out  3  remaining lives
score  out  16  4-digit BCD, [15:12] thousands
level  out  4  binary level, starts at 1
ball_speed  out  3  min(BASE_SPEED+level-1, MAX_SPEED)
endGame  out  1  high in OVER

Behaviour:
- Reset (synchronous, active-high) sets: state=IDLE, ball_hold=1, ball_serve=0, brick_reload=0, lives=LIVES_INIT, score=0, level=1, ball_speed=BASE_SPEED, endGame=0, frame counter=0, event latches=0.
- Event latching:
  - brick_hit and ball_lost are latched sticky during a frame.
  - They are consumed on frame_tick.
  - A brick_hit that arrives in the same cycle as frame_tick counts toward the current frame.
  - Multiple brick_hit pulses in one frame add points once per pulse. Use an up-to-7 pending counter that saturates.
- Start edge: a press is start_n going 1->0 as sampled on frame_tick. A held button never retriggers.
- State transitions (evaluated only on frame_tick):
  - IDLE: on start edge, pulse brick_reload, load lives=LIVES_INIT, score=0, level=1, go to SERVE.
  - SERVE: ball_hold=1; the frame counter counts frames. On a start edge or when the counter reaches SERVE_FRAMES-1, pulse ball_serve, set ball_hold=0, go to PLAY.
  - PLAY: apply pending score first. Then:
    - If ball_lost and lives==1: lives=0, go to OVER.
    - Else if ball_lost: lives-1, go to LOST.
    - Else if bricks_clear: go to LEVEL_UP.
    - Priority: ball_lost over bricks_clear.
  - LOST: ball_hold=1; after LOST_FRAMES go to SERVE.
  - LEVEL_UP: ball_hold=1. After LEVELUP_FRAMES, level+1 (saturates at 15), pulse brick_reload, go to SERVE.
  - OVER: endGame=1. On a start edge, behave as IDLE's start (new game, endGame=0).
- The frame counter clears on every state change.
- brick_hit and ball_lost outside PLAY are discarded.
- ball_serve and brick_reload are exactly one clock wide, asserted in the cycle after frame_tick.
- Score arithmetic:
  - BCD add with digit carry.
  - Saturates at 16'h9999 and never wraps.
  - Each add result is registered; digits are always 0..9.
- ball_speed is recomputed combinationally from level, then registered. Level 6 with defaults gives 6 (cap).
- Reset mid-game returns to IDLE within one clock regardless of state or pending events.

Optional Feature:
Macro BREAKOUT_EXTRA_LIFE_EN.
- Defined: each time the score crosses a thousands boundary (thousands digit increments), lives+1, saturating at 7. A crossing in the same frame as a ball_lost is applied before the loss check.
- Undefined: lives only decrease; the extra-life logic is absent.

Test Plan:
1. Reset, then start_n pressed on frame 5 -> brick_reload pulse, state=SERVE, lives=3, score=0000, level=1, ball_hold=1.
2. In SERVE with no press -> ball_serve pulses after exactly 60 frame_ticks, state=PLAY, ball_hold=0.
3. In PLAY with score=0x0098, three brick_hit pulses in one frame -> score=0x0101 after that frame_tick; with score=0x9998 plus 5 hits -> 0x9999.
4. In PLAY with lives=2: ball_lost -> lives=1, LOST for 90 frames, then SERVE. A second ball_lost -> lives=0, state=OVER, endGame=1. A start edge then -> IDLE-style restart with endGame=0.
5. In PLAY, bricks_clear and ball_lost in the same frame -> LOST (loss wins). bricks_clear alone at level 5 -> LEVEL_UP, then after 120 frames level=6, ball_speed=6, brick_reload pulse.
6. With BREAKOUT_EXTRA_LIFE_EN, score 0x0999 plus 1 hit -> score 0x1000, lives+1. Assert reset mid-LEVEL_UP -> next clock state=IDLE and all outputs at reset values.

Source files
------------

// File: rtl/breakout_game_ctrl_if.sv
// Breakout game sequencer bus: frame/event inputs from the sync generator and
// ball/paddle/brick datapath, phase and scoreboard outputs back to them.
// master = datapath/sync side, slave = game controller.
interface breakout_game_ctrl_if;
  logic        frame_tick;
  logic        start_n;
  logic        brick_hit;
  logic        ball_lost;
  logic        bricks_clear;
  logic [2:0]  state;
  logic        ball_hold;
  logic        ball_serve;
  logic        brick_reload;
  logic [2:0]  lives;
  logic [15:0] score;
  logic [3:0]  level;
  logic [2:0]  ball_speed;
  logic        endGame;

  modport master (
    output frame_tick, start_n, brick_hit, ball_lost, bricks_clear,
    input  state, ball_hold, ball_serve, brick_reload, lives, score, level,
           ball_speed, endGame
  );

  modport slave (
    input  frame_tick, start_n, brick_hit, ball_lost, bricks_clear,
    output state, ball_hold, ball_serve, brick_reload, lives, score, level,
           ball_speed, endGame
  );
endinterface

// File: rtl/breakout_game_ctrl.sv
// Frame-rate game sequencer for the breakout playfield: phase, lives, BCD
// score, level and ball speed. Decisions advance only on frame_tick; brick
// hits and ball losses are latched during the frame and consumed on the tick.
// Optional macro BREAKOUT_EXTRA_LIFE_EN: award a life (saturating at 7) each
// time the score's thousands digit increments.
module breakout_game_ctrl #(
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned BRICK_POINTS   = 1,
  parameter int unsigned BASE_SPEED     = 2,
  parameter int unsigned MAX_SPEED      = 6,
  parameter int unsigned SERVE_FRAMES   = 60,
  parameter int unsigned LOST_FRAMES    = 90,
  parameter int unsigned LEVELUP_FRAMES = 120
) (
  input  logic                 clock,
  input  logic                 reset,
  breakout_game_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_LOST     = 3'd3,
    ST_LEVEL_UP = 3'd4,
    ST_OVER     = 3'd5
  } state_e;

  localparam int unsigned FRAMES_A   = (SERVE_FRAMES > LOST_FRAMES) ? SERVE_FRAMES : LOST_FRAMES;
  localparam int unsigned FRAMES_MAX = (FRAMES_A > LEVELUP_FRAMES) ? FRAMES_A : LEVELUP_FRAMES;
  localparam int unsigned CNT_W      = $clog2(FRAMES_MAX + 1);

  localparam logic [CNT_W-1:0] SERVE_LAST   = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] LOST_LAST    = CNT_W'(LOST_FRAMES - 1);
  localparam logic [CNT_W-1:0] LEVELUP_LAST = CNT_W'(LEVELUP_FRAMES - 1);
  localparam logic [2:0]       LIVES_RST    = 3'(LIVES_INIT);
  localparam logic [2:0]       SPEED_RST    = 3'(BASE_SPEED);
  localparam logic [4:0]       SPEED_BASE   = 5'(BASE_SPEED);
  localparam logic [4:0]       SPEED_CAP    = 5'(MAX_SPEED);
  localparam logic [5:0]       POINTS       = 6'(BRICK_POINTS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [2:0]       hit_cnt_q, hit_cnt_d;
  logic             lost_q, lost_d;
  logic             start_prev_q, start_prev_d;
  logic             ball_hold_q, ball_hold_d;
  logic             ball_serve_q, ball_serve_d;
  logic             brick_reload_q, brick_reload_d;
  logic [2:0]       lives_q, lives_d;
  logic [15:0]      score_q, score_d;
  logic [3:0]       level_q, level_d;
  logic [2:0]       ball_speed_q, ball_speed_d;
  logic             end_game_q, end_game_d;

  logic [2:0]  hits_now;
  logic        lost_now;
  logic        start_edge;
  logic [5:0]  pts;
  logic [15:0] add_bcd;
  logic [15:0] score_sum;
  logic [15:0] score_add;
  logic [4:0]  digit_sum;
  logic        carry;
  logic [2:0]  lives_bonus;
  logic [4:0]  spd_sum;

  // Events seen this frame including the tick cycle itself, plus start edge.
  always_comb begin
    hits_now   = (hit_cnt_q == 3'd7) ? 3'd7 : hit_cnt_q + 3'(bus.brick_hit);
    lost_now   = lost_q | bus.ball_lost;
    start_edge = bus.frame_tick & start_prev_q & ~bus.start_n;
  end

  // Saturating 4-digit BCD add of this frame's points, and extra-life award.
  always_comb begin
    pts       = 6'(hits_now) * POINTS;
    add_bcd   = {8'h00, 4'(pts / 6'd10), 4'(pts % 6'd10)};
    score_sum = '0;
    digit_sum = '0;
    carry     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      digit_sum = 5'(score_q[4*i +: 4]) + 5'(add_bcd[4*i +: 4]) + 5'(carry);
      if (digit_sum > 5'd9) begin
        score_sum[4*i +: 4] = 4'(digit_sum - 5'd10);
        carry               = 1'b1;
      end else begin
        score_sum[4*i +: 4] = 4'(digit_sum);
        carry               = 1'b0;
      end
    end
    score_add   = carry ? 16'h9999 : score_sum;
    lives_bonus = lives_q;
`ifdef BREAKOUT_EXTRA_LIFE_EN
    if ((score_add[15:12] != score_q[15:12]) && (lives_q != 3'd7)) begin
      lives_bonus = lives_q + 3'd1;
    end
`else
`endif
  end

  // Next-state, event latches, frame counter and registered outputs.
  always_comb begin
    state_d        = state_q;
    frame_cnt_d    = frame_cnt_q;
    hit_cnt_d      = 3'd0;
    lost_d         = 1'b0;
    start_prev_d   = start_prev_q;
    ball_serve_d   = 1'b0;
    brick_reload_d = 1'b0;
    lives_d        = lives_q;
    score_d        = score_q;
    level_d        = level_q;

    if ((state_q == ST_PLAY) && !bus.frame_tick) begin
      hit_cnt_d = hits_now;
      lost_d    = lost_now;
    end

    if (bus.frame_tick) begin
      start_prev_d = bus.start_n;
      unique case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start_edge) begin
            brick_reload_d = 1'b1;
            lives_d        = LIVES_RST;
            score_d        = '0;
            level_d        = 4'd1;
            state_d        = ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (start_edge || (frame_cnt_q == SERVE_LAST)) begin
            ball_serve_d = 1'b1;
            state_d      = ST_PLAY;
          end
        end
        ST_PLAY: begin
          score_d = score_add;
          lives_d = lives_bonus;
          if (lost_now) begin
            if (lives_bonus == 3'd1) begin
              lives_d = 3'd0;
              state_d = ST_OVER;
            end else begin
              lives_d = lives_bonus - 3'd1;
              state_d = ST_LOST;
            end
          end else if (bus.bricks_clear) begin
            state_d = ST_LEVEL_UP;
          end
        end
        ST_LOST: begin
          if (frame_cnt_q == LOST_LAST) begin
            state_d = ST_SERVE;
          end
        end
        ST_LEVEL_UP: begin
          if (frame_cnt_q == LEVELUP_LAST) begin
            level_d        = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
            brick_reload_d = 1'b1;
            state_d        = ST_SERVE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (state_d != state_q) begin
        frame_cnt_d = '0;
      end else if ((state_q == ST_SERVE) || (state_q == ST_LOST) ||
                   (state_q == ST_LEVEL_UP)) begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end

    ball_hold_d  = (state_d != ST_PLAY);
    end_game_d   = (state_d == ST_OVER);
    spd_sum      = SPEED_BASE + 5'(level_d) - 5'd1;
    ball_speed_d = (spd_sum > SPEED_CAP) ? 3'(SPEED_CAP) : 3'(spd_sum);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      frame_cnt_q    <= '0;
      hit_cnt_q      <= 3'd0;
      lost_q         <= 1'b0;
      start_prev_q   <= 1'b1;
      ball_hold_q    <= 1'b1;
      ball_serve_q   <= 1'b0;
      brick_reload_q <= 1'b0;
      lives_q        <= LIVES_RST;
      score_q        <= '0;
      level_q        <= 4'd1;
      ball_speed_q   <= SPEED_RST;
      end_game_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      hit_cnt_q      <= hit_cnt_d;
      lost_q         <= lost_d;
      start_prev_q   <= start_prev_d;
      ball_hold_q    <= ball_hold_d;
      ball_serve_q   <= ball_serve_d;
      brick_reload_q <= brick_reload_d;
      lives_q        <= lives_d;
      score_q        <= score_d;
      level_q        <= level_d;
      ball_speed_q   <= ball_speed_d;
      end_game_q     <= end_game_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.ball_hold    = ball_hold_q;
  assign bus.ball_serve   = ball_serve_q;
  assign bus.brick_reload = brick_reload_q;
  assign bus.lives        = lives_q;
  assign bus.score        = score_q;
  assign bus.level        = level_q;
  assign bus.ball_speed   = ball_speed_q;
  assign bus.endGame      = end_game_q;

endmodule
